uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
Parametrised framed UART transmitter that generalises the fixed 20-bit, 3-byte Bluetooth sender. It accepts one DATA_W-bit word over a valid/ready handshake and packs it MSB-first into bytes. It then serialises one frame, in order: optional header, payload bytes, optional checksum, tail byte. Serialisation is 8N1 on a single line with a built-in baud generator, so no external bit-level transmitter or clock divider is needed.

Parameters:
DATA_W, 20, payload width in bits (1..64); NBYTES = ceil(DATA_W/8) is a derived localparam
CLKS_PER_BIT, 10417, CLK cycles per UART bit (100 MHz / 9600); must be >= 2
HDR_EN, 1, 1 = prepend HEADER byte
HEADER, 8'hAA, header byte value
CKSUM_EN, 1, 1 = append checksum byte after payload
TAIL, 8'hFF, terminator byte, always sent last
GAP_BITS, 0, idle-high bit periods inserted between consecutive bytes of a frame (0..15)

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-high reset
tx_data  input  DATA_W  payload word
tx_vld  input  1  payload valid
tx_rdy  output  1  block idle and able to accept a word
busy  output  1  frame in progress (equals ~tx_rdy)
frame_done  output  1  one-cycle pulse when the tail stop bit completes
tx  output  1  serial line, idle high

Behaviour:
- Reset values (asynchronous, take effect immediately): tx=1, tx_rdy=1, busy=0, frame_done=0. All counters and the state machine return to IDLE. The shift register and the latched payload are cleared.
- A reset asserted mid-frame aborts the frame, drives tx high at once and discards the rest of the frame. No frame_done is generated.
- Acceptance: a word is accepted on the rising edge where tx_vld && tx_rdy.
  - tx_data is latched into a snapshot register; later changes to tx_data do not affect the frame.
  - tx_rdy and busy change state in the following cycle.
  - The first start bit begins in that same following cycle (latency of 1 cycle from acceptance to tx=0).
- tx_vld while busy is ignored; nothing is queued.
- Packing:
  - padded = {tx_data, (NBYTES*8-DATA_W) zero bits}.
  - Payload byte k (k=0..NBYTES-1) = padded[NBYTES*8-1-8k -: 8], so byte 0 carries the MSBs.
- Checksum = sum of payload bytes mod 256. The header and tail are excluded.
- Frame order: HEADER (if HDR_EN), payload bytes 0..NBYTES-1, checksum (if CKSUM_EN), TAIL. Frame length F = HDR_EN + NBYTES + CKSUM_EN + 1 bytes.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- State machine:
  - IDLE -> START on acceptance.
  - START -> DATA after 1 bit period.
  - DATA -> STOP after 8 bit periods.
  - STOP -> GAP if GAP_BITS>0 and more bytes remain.
  - STOP -> START if GAP_BITS=0 and more bytes remain.
  - STOP -> IDLE after the last byte.
  - GAP -> START after GAP_BITS bit periods, with tx held high.
- Counters:
  - The baud counter reloads on every bit boundary.
  - The bit index wraps 7 -> 0 on DATA exit.
  - The byte index runs 0..F-1 and is cleared on entry to IDLE.
- Completion: on the cycle after the last stop bit period ends, tx_rdy=1, busy=0, frame_done=1 for exactly one cycle.
- Back-to-back frames: if tx_vld is high in the frame_done cycle, the word is accepted and its start bit begins in the next cycle. That leaves exactly one idle-high cycle between frames.
- Frame duration in cycles, from first start bit to the end of the last stop bit: F*10*CLKS_PER_BIT + (F-1)*GAP_BITS*CLKS_PER_BIT.
- tx is driven from a register, so there is no combinational path from inputs to tx.

Test Plan:
1. Defaults with CLKS_PER_BIT=4, tx_data=20'hABCDE, tx_vld for 1 cycle.
   - Required: line decodes to bytes AA AB CD E0 58 FF.
   - tx falls 1 cycle after acceptance; frame lasts 240 cycles; frame_done pulses once; tx_rdy low throughout.
2. Reset values and idle line: assert RST asynchronously between clock edges.
   - Required: tx=1, tx_rdy=1, busy=0, frame_done=0 immediately.
   - With no tx_vld, tx stays 1 indefinitely.
3. HDR_EN=0, CKSUM_EN=0, DATA_W=8, GAP_BITS=2, CLKS_PER_BIT=4, tx_data=8'h5A.
   - Required: bytes 5A FF with 8 idle-high cycles between them; total 88 cycles.
4. tx_vld held high with tx_data changing every cycle (starting 20'h12345).
   - Required: the first frame carries only the snapshot value 20'h12345, i.e. AA 12 34 50 96 FF.
   - The second frame's start bit follows frame_done by exactly 1 cycle.
5. Reset mid-frame: assert RST during the payload DATA bits of the second byte, release it, then send 20'h00001.
   - Required: tx=1 immediately on reset and no frame_done for the aborted frame.
   - The new frame is AA 00 00 10 10 FF.
6. Checksum wrap: DATA_W=24, tx_data=24'hFFFFFF.
   - Required: checksum byte FD (0x2FD mod 256); frame AA FF FF FF FD FF.

Source files
------------

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
// Framed 8N1 UART transmitter with a built-in baud generator.
// A DATA_W-bit word is accepted over a valid/ready handshake, split MSB-first
// into bytes and sent as one frame:
//   [HEADER] payload byte 0 .. NBYTES-1 [checksum] TAIL
// GAP_BITS idle-high bit periods can be placed between the bytes of a frame.
//
// Ports:
//   CLK         system clock
//   RST         asynchronous active-high reset
//   tx_data     payload word, captured on acceptance
//   tx_vld      payload valid
//   tx_rdy      idle and able to accept a word
//   busy        frame in progress (always ~tx_rdy)
//   frame_done  one-cycle pulse after the tail stop bit completes
//   tx          registered serial line, idle high

module uart_frame_tx #(
  parameter int         DATA_W       = 20,
  parameter int         CLKS_PER_BIT = 10417,
  parameter bit         HDR_EN       = 1'b1,
  parameter logic [7:0] HEADER       = 8'hAA,
  parameter bit         CKSUM_EN     = 1'b1,
  parameter logic [7:0] TAIL         = 8'hFF,
  parameter int         GAP_BITS     = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_vld,
  output logic              tx_rdy,
  output logic              busy,
  output logic              frame_done,
  output logic              tx
);

  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int NB8    = NBYTES * 8;
  localparam int PAD    = NB8 - DATA_W;
  localparam int F      = int'(HDR_EN) + NBYTES + int'(CKSUM_EN) + 1;
  localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BYTE = 4'(F - 1);
  localparam logic [3:0]       LAST_GAP  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   baud_q, baud_n;
  logic [2:0]         bit_q, bit_n;
  logic [3:0]         byte_q, byte_n;
  logic [3:0]         gap_q, gap_n;
  logic [6:0]         shift_q, shift_n;
  logic [DATA_W-1:0]  data_q, data_n;
  logic               tx_q, tx_n;
  logic               done_q, done_n;

  logic               bit_end;
  logic [NB8-1:0]     padded;
  logic [7:0]         cksum;
  logic [7:0]         cur_byte;

  assign bit_end = (baud_q == '0);

  // Payload left-aligned so byte 0 always carries the MSBs.
  assign padded = NB8'(data_q) << PAD;

  always_comb begin
    cksum = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      cksum = cksum + padded[8*k +: 8];
    end
  end

  // Byte currently being framed, selected by position within the frame.
  always_comb begin
    int             k;
    logic [NB8-1:0] sel;
    k   = int'(byte_q) - int'(HDR_EN);
    sel = '0;
    if (HDR_EN && byte_q == 4'd0) begin
      cur_byte = HEADER;
    end else if (k < NBYTES) begin
      sel      = padded >> (8 * (NBYTES - 1 - k));
      cur_byte = sel[7:0];
    end else if (CKSUM_EN && k == NBYTES) begin
      cur_byte = cksum;
    end else begin
      cur_byte = TAIL;
    end
  end

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    gap_n   = gap_q;
    shift_n = shift_q;
    data_n  = data_q;
    tx_n    = tx_q;
    done_n  = 1'b0;

    if (state_q != S_IDLE) begin
      baud_n = bit_end ? BAUD_LAST : baud_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_n = 1'b1;
        if (tx_vld) begin
          data_n  = tx_data;
          state_n = S_START;
          baud_n  = BAUD_LAST;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          tx_n    = cur_byte[0];
          shift_n = cur_byte[7:1];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_n   = 3'd0;
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_q + 3'd1;
            tx_n    = shift_q[0];
            shift_n = {1'b0, shift_q[6:1]};
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_q == LAST_BYTE) begin
            state_n = S_IDLE;
            byte_n  = 4'd0;
            done_n  = 1'b1;
          end else begin
            byte_n = byte_q + 4'd1;
            if (GAP_BITS > 0) begin
              state_n = S_GAP;
              gap_n   = 4'd0;
            end else begin
              state_n = S_START;
              tx_n    = 1'b0;
            end
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (gap_q == LAST_GAP) begin
            gap_n   = 4'd0;
            state_n = S_START;
            tx_n    = 1'b0;
          end else begin
            gap_n = gap_q + 4'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      gap_q   <= gap_n;
      shift_q <= shift_n;
      data_q  <= data_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  assign tx_rdy     = (state_q == S_IDLE);
  assign busy       = ~tx_rdy;
  assign frame_done = done_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: three instances (default frame, short frame with
// gaps, 24-bit payload) share clock and reset; a line decoder checks every
// byte against a scoreboard filled when stimulus is driven.

module tb_uart_frame_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic [19:0] d0;
  logic [7:0]  d1;
  logic [23:0] d2;
  logic        vld0, vld1, vld2;
  logic        rdy0, rdy1, rdy2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic        tx0, tx1, tx2;

  int          sel;
  logic        line, rdy, bsy, done;

  int          total;
  int          bad;
  int          cyc;
  int          done_cnt;
  logic [7:0]  sb[$];
  int          starts[$];

  uart_frame_tx #(.CLKS_PER_BIT(CPB)) u0 (
    .CLK(clk), .RST(rst), .tx_data(d0), .tx_vld(vld0),
    .tx_rdy(rdy0), .busy(busy0), .frame_done(done0), .tx(tx0)
  );

  uart_frame_tx #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .HDR_EN(1'b0), .CKSUM_EN(1'b0), .GAP_BITS(2)
  ) u1 (
    .CLK(clk), .RST(rst), .tx_data(d1), .tx_vld(vld1),
    .tx_rdy(rdy1), .busy(busy1), .frame_done(done1), .tx(tx1)
  );

  uart_frame_tx #(.DATA_W(24), .CLKS_PER_BIT(CPB)) u2 (
    .CLK(clk), .RST(rst), .tx_data(d2), .tx_vld(vld2),
    .tx_rdy(rdy2), .busy(busy2), .frame_done(done2), .tx(tx2)
  );

  always_comb begin
    case (sel)
      0:       begin line = tx0; rdy = rdy0; bsy = busy0; done = done0; end
      1:       begin line = tx1; rdy = rdy1; bsy = busy1; done = done1; end
      default: begin line = tx2; rdy = rdy2; bsy = busy2; done = done2; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference frame: header, payload bytes MSB-first, checksum, tail.
  task automatic push_frame(input int dw, input bit hdr, input bit ck, input logic [63:0] d);
    int          nb;
    logic [63:0] p;
    logic [7:0]  b;
    logic [7:0]  s;
    nb = (dw + 7) / 8;
    p  = d << (nb * 8 - dw);
    s  = 8'h00;
    if (hdr) sb.push_back(8'hAA);
    for (int k = 0; k < nb; k++) begin
      b = 8'(p >> (8 * (nb - 1 - k)));
      sb.push_back(b);
      s = s + b;
    end
    if (ck) sb.push_back(s);
    sb.push_back(8'hFF);
  endtask

  // Line decoder: samples each bit mid-period; bytes hit by reset are dropped.
  initial begin : monitor
    logic [9:0] bits;
    bit         aborted;
    int         t_start;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && line === 1'b0) begin
        t_start = cyc;
        aborted = 1'b0;
        bits    = '0;
        for (int off = 0; off < 10 * CPB - 1; off++) begin
          if (off > 0) @(negedge clk);
          if (rst !== 1'b0) aborted = 1'b1;
          if (off % CPB == CPB / 2) bits[off / CPB] = line;
        end
        if (!aborted) begin
          starts.push_back(t_start);
          check("start_bit", 32'(bits[0]), 0);
          check("stop_bit", 32'(bits[9]), 1);
          check("sb_nonempty", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) check("byte", 32'(bits[8:1]), 32'(sb.pop_front()));
        end
      end
    end
  end

  // Waits (bounded) for frame_done and checks duration and handshake state.
  task automatic finish_frame(input string tag, input int t0, input int exp_cycles);
    int rdy_hi = 0;
    while (done !== 1'b1 && cyc - t0 < 4000) begin
      if (rdy !== 1'b0) rdy_hi++;
      @(negedge clk);
    end
    check({tag, "_dur"}, cyc - t0, exp_cycles);
    check({tag, "_rdy_low"}, rdy_hi, 0);
    check({tag, "_rdy_done"}, 32'(rdy), 1);
    check({tag, "_busy_done"}, 32'(bsy), 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done), 0);
    repeat (3) @(negedge clk);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Called at a negedge with tx_vld already raised; acceptance on next edge.
  task automatic run_frame(input string tag, input int exp_cycles);
    int t0;
    @(posedge clk);
    #1;
    check({tag, "_txfall"}, 32'(line), 0);
    check({tag, "_rdy_fall"}, 32'(rdy), 0);
    check({tag, "_busy_rise"}, 32'(bsy), 1);
    t0 = cyc;
    @(negedge clk);
    vld0 = 1'b0;
    vld1 = 1'b0;
    vld2 = 1'b0;
    finish_frame(tag, t0, exp_cycles);
  endtask

  task automatic idle_check(input string tag, input int n);
    int lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (line !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    int accepted;
    int n;
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    sel      = 0;
    rst      = 1'b0;
    vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;

    // Reset asserted between clock edges takes effect at once.
    #2 rst = 1'b1;
    #1;
    check("rst_tx", 32'(line), 1);
    check("rst_rdy", 32'(rdy), 1);
    check("rst_busy", 32'(bsy), 0);
    check("rst_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_check("idle_line", 50);

    // Default frame.
    done_cnt = 0;
    @(negedge clk);
    d0 = 20'hABCDE; vld0 = 1'b1;
    push_frame(20, 1'b1, 1'b1, 64'(d0));
    run_frame("t1", 240);
    check("t1_done_cnt", done_cnt, 1);

    // Short frame with inter-byte gap.
    sel = 1;
    starts.delete();
    @(negedge clk);
    d1 = 8'h5A; vld1 = 1'b1;
    push_frame(8, 1'b0, 1'b0, 64'(d1));
    run_frame("t3", 88);
    check("t3_nbytes", starts.size(), 2);
    if (starts.size() == 2) check("t3_gap", starts[1] - starts[0], 10 * CPB + 2 * CPB);

    // vld held high with data changing: snapshot and back-to-back frames.
    sel = 0;
    @(negedge clk);
    d0 = 20'h12345; vld0 = 1'b1;
    push_frame(20, 1'b1, 1'b1, 64'(d0));
    accepted = 1;
    n = 0;
    while (accepted < 2 && n < 2000) begin
      @(negedge clk);
      n++;
      d0 = d0 + 20'h01111;
      if (rdy === 1'b1) begin
        check("t4_done_at_rdy", 32'(done), 1);
        check("t4_idle_cycle", 32'(line), 1);
        push_frame(20, 1'b1, 1'b1, 64'(d0));
        accepted++;
      end
    end
    check("t4_second_accept", accepted, 2);
    @(negedge clk);
    check("t4_start_after_done", 32'(line), 0);
    vld0 = 1'b0;
    finish_frame("t4b", cyc, 240);

    // Reset in the middle of payload byte 0 (second byte on the line).
    done_cnt = 0;
    @(negedge clk);
    d0 = 20'hABCDE; vld0 = 1'b1;
    push_frame(20, 1'b1, 1'b1, 64'(d0));
    @(posedge clk);
    @(negedge clk);
    vld0 = 1'b0;
    repeat (54) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_tx", 32'(line), 1);
    check("t5_rst_rdy", 32'(rdy), 1);
    check("t5_rst_done", 32'(done), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check("t5_idle", 20);
    check("t5_no_done", done_cnt, 0);
    @(negedge clk);
    d0 = 20'h00001; vld0 = 1'b1;
    push_frame(20, 1'b1, 1'b1, 64'(d0));
    run_frame("t5", 240);
    check("t5_done_cnt", done_cnt, 1);

    // Checksum wrap with a 24-bit payload.
    sel = 2;
    @(negedge clk);
    d2 = 24'hFFFFFF; vld2 = 1'b1;
    push_frame(24, 1'b1, 1'b1, 64'(d2));
    run_frame("t6", 240);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
